// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing an 8-bit register file with auto-incrementing pointer.
// Define I2C_SLAVE_GENERAL_CALL_EN to accept general-call (7'h00, W) writes into reg[0].
`timescale 1ns/1ps
module i2c_slave_regfile #(
   parameter logic [6:0] ADDRESS   = 7'h55,
   parameter int         NUM_REGS  = 16,
   parameter logic [7:0] REG_RESET = 8'h00,
   localparam int        PTR_W     = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             scl_i,
   input  logic             sda_i,
   output logic             sda_oe,
   input  logic [PTR_W-1:0] host_raddr,
   output logic [7:0]       host_rdata,
   output logic             wr_pulse,
   output logic [PTR_W-1:0] wr_addr,
   output logic [7:0]       wr_data,
   output logic             busy
);

`ifdef I2C_SLAVE_GENERAL_CALL_EN
   localparam logic GC_EN = 1'b1;
`else
   localparam logic GC_EN = 1'b0;
`endif

   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       scl_sync_q, sda_sync_q;
   logic             scl_dly_q, sda_dly_q;
   logic [2:0]       cnt_q, cnt_d;
   logic [6:0]       sh_q, sh_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             oe_q, oe_d, busy_q, busy_d, rw_q, rw_d, gc_q, gc_d;
   logic             wr_pulse_q, wr_pulse_d;
   logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]       wr_data_q, wr_data_d;
   logic [7:0]       regs_q [NUM_REGS];
   logic [7:0]       host_rdata_q;

   logic       scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
   logic [7:0] byte_s;
   logic       last_bit_s, rd_bit_s, gc_hit_s;

   assign scl_s      = scl_sync_q[1];
   assign sda_s      = sda_sync_q[1];
   assign scl_rise_s = scl_s & ~scl_dly_q;
   assign scl_fall_s = ~scl_s & scl_dly_q;
   assign start_s    = scl_s & scl_dly_q & ~sda_s & sda_dly_q;
   assign stop_s     = scl_s & scl_dly_q & sda_s & ~sda_dly_q;
   assign byte_s     = {sh_q, sda_s};
   assign last_bit_s = (cnt_q == 3'd0);
   assign rd_bit_s   = regs_q[ptr_q][cnt_q];
   assign gc_hit_s   = GC_EN && (byte_s == 8'h00);

   // Protocol engine: data is sampled on SCL rise, SDA drive only moves on SCL fall.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      ptr_d      = ptr_q;
      oe_d       = oe_q;
      busy_d     = busy_q;
      rw_d       = rw_q;
      gc_d       = gc_q;
      wr_pulse_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      if (stop_s) begin
         state_d = IDLE;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else if (start_s) begin
         state_d = ADDR;
         cnt_d   = 3'd7;
         oe_d    = 1'b0;
      end else if (scl_fall_s) begin
         case (state_q)
            ADDR_ACK, PTR_ACK, WDATA_ACK: oe_d = 1'b1;
            RDATA:                        oe_d = ~rd_bit_s;
            default:                      oe_d = 1'b0;
         endcase
      end else if (scl_rise_s) begin
         case (state_q)
            ADDR: begin
               sh_d  = byte_s[6:0];
               cnt_d = cnt_q - 3'd1;
               if (!last_bit_s) begin
                  state_d = ADDR;
               end else if (byte_s[7:1] == ADDRESS) begin
                  state_d = ADDR_ACK;
                  rw_d    = byte_s[0];
                  gc_d    = 1'b0;
                  busy_d  = 1'b1;
               end else if (gc_hit_s) begin
                  state_d = ADDR_ACK;
                  rw_d    = 1'b0;
                  gc_d    = 1'b1;
                  busy_d  = 1'b1;
               end else begin
                  state_d = IGNORE;
                  busy_d  = 1'b0;
               end
            end
            PTR: begin
               sh_d  = byte_s[6:0];
               cnt_d = cnt_q - 3'd1;
               if (last_bit_s) begin
                  ptr_d   = byte_s[PTR_W-1:0];
                  state_d = PTR_ACK;
               end else begin
                  state_d = PTR;
               end
            end
            WDATA: begin
               sh_d  = byte_s[6:0];
               cnt_d = cnt_q - 3'd1;
               if (last_bit_s) begin
                  wr_pulse_d = 1'b1;
                  wr_addr_d  = gc_q ? {PTR_W{1'b0}} : ptr_q;
                  wr_data_d  = byte_s;
                  ptr_d      = gc_q ? ptr_q : ptr_q + PTR_ONE;
                  state_d    = WDATA_ACK;
               end else begin
                  state_d = WDATA;
               end
            end
            RDATA: begin
               cnt_d   = cnt_q - 3'd1;
               state_d = last_bit_s ? RDATA_ACK : RDATA;
            end
            RDATA_ACK: begin
               if (!sda_s) begin
                  ptr_d   = ptr_q + PTR_ONE;
                  cnt_d   = 3'd7;
                  state_d = RDATA;
               end else begin
                  state_d = IGNORE;
               end
            end
            ADDR_ACK: begin
               cnt_d   = 3'd7;
               state_d = rw_q ? RDATA : (gc_q ? WDATA : PTR);
            end
            PTR_ACK, WDATA_ACK: begin
               cnt_d   = 3'd7;
               state_d = WDATA;
            end
            default: state_d = state_q;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Pad synchronisers and protocol state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_dly_q  <= 1'b1;
         sda_dly_q  <= 1'b1;
         state_q    <= IDLE;
         cnt_q      <= 3'd7;
         sh_q       <= 7'h00;
         ptr_q      <= {PTR_W{1'b0}};
         oe_q       <= 1'b0;
         busy_q     <= 1'b0;
         rw_q       <= 1'b0;
         gc_q       <= 1'b0;
         wr_pulse_q <= 1'b0;
         wr_addr_q  <= {PTR_W{1'b0}};
         wr_data_q  <= 8'h00;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_i};
         sda_sync_q <= {sda_sync_q[0], sda_i};
         scl_dly_q  <= scl_s;
         sda_dly_q  <= sda_s;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         ptr_q      <= ptr_d;
         oe_q       <= oe_d;
         busy_q     <= busy_d;
         rw_q       <= rw_d;
         gc_q       <= gc_d;
         wr_pulse_q <= wr_pulse_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   // Register file; the host port sees the pre-write value on a same-cycle collision.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= REG_RESET;
         end
         host_rdata_q <= 8'h00;
      end else begin
         if (wr_pulse_d) begin
            regs_q[wr_addr_d] <= wr_data_d;
         end
         host_rdata_q <= regs_q[host_raddr];
      end
   end

   assign sda_oe     = oe_q;
   assign busy       = busy_q;
   assign wr_pulse   = wr_pulse_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-banged I2C master against an open-drain bus model.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;
   localparam int Q = 50;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic [3:0] host_raddr = 4'd0;
   logic       sda_oe, busy, wr_pulse;
   logic [3:0] wr_addr;
   logic [7:0] wr_data, host_rdata;
   logic       sda_line;

   int checks = 0;
   int failures = 0;
   int oe_cnt = 0;
   logic [11:0] wq[$];
   logic [7:0]  preq[$];

   assign sda_line = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_slave_regfile dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scl_i      (scl_m),
      .sda_i      (sda_line),
      .sda_oe     (sda_oe),
      .host_raddr (host_raddr),
      .host_rdata (host_rdata),
      .wr_pulse   (wr_pulse),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy)
   );

   // Records every write strobe, the host read data seen alongside it, and any SDA drive.
   always @(negedge clk) begin
      if (wr_pulse) begin
         wq.push_back({wr_addr, wr_data});
         preq.push_back(host_rdata);
      end
      if (sda_oe) oe_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b, output logic r);
      sda_m = b;
      #Q scl_m = 1'b1;
      #Q r = sda_line;
      #Q scl_m = 1'b0;
      #Q;
   endtask

   task automatic xbyte(input logic [7:0] tx, input logic nin, output logic [7:0] rx, output logic nrx);
      logic t;
      for (int i = 7; i >= 0; i--) begin
         send_bit(tx[i], t);
         rx[i] = t;
      end
      send_bit(nin, nrx);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      #Q scl_m = 1'b1;
      #Q sda_m = 1'b0;
      #Q scl_m = 1'b0;
      #Q;
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;
      #Q scl_m = 1'b1;
      #Q sda_m = 1'b1;
      #Q;
   endtask

   task automatic host_rd(input logic [3:0] idx, input logic [7:0] exp, input string tag);
      host_raddr = idx;
      @(negedge clk);
      @(negedge clk);
      chk(tag, 32'(host_rdata), 32'(exp));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] rx;
      logic a, t;
      int n0, o0;

      repeat (4) @(negedge clk);
      chk("rst_sda_oe", 32'(sda_oe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_host_rdata", 32'(host_rdata), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Write 0x11, 0x22 starting at reg 3
      host_raddr = 4'd3;
      i2c_start();
      xbyte(8'hAA, 1'b1, rx, a);  chk("t1_addr_ack", 32'(a), 32'd0);
      chk("t1_busy", 32'(busy), 32'd1);
      xbyte(8'h03, 1'b1, rx, a);  chk("t1_ptr_ack", 32'(a), 32'd0);
      xbyte(8'h11, 1'b1, rx, a);  chk("t1_d0_ack", 32'(a), 32'd0);
      xbyte(8'h22, 1'b1, rx, a);  chk("t1_d1_ack", 32'(a), 32'd0);
      i2c_stop();
      repeat (4) @(negedge clk);
      chk("t1_busy_stop", 32'(busy), 32'd0);
      chk("t1_npulse", 32'(wq.size()), 32'd2);
      if (wq.size() >= 2) begin
         chk("t1_w0", 32'(wq[0]), 32'h311);
         chk("t1_w1", 32'(wq[1]), 32'h422);
         chk("t1_prewrite", 32'(preq[0]), 32'h00);
         chk("t1_rd3_at_w1", 32'(preq[1]), 32'h11);
      end
      host_rd(4'd4, 8'h22, "t1_rd4");
      host_rd(4'd3, 8'h11, "t1_rd3");

      // Pointer modulo and wrap on write, then read back across the wrap
      n0 = wq.size();
      i2c_start();
      xbyte(8'hAA, 1'b1, rx, a);  chk("t2_addr_ack", 32'(a), 32'd0);
      xbyte(8'h3F, 1'b1, rx, a);  chk("t2_ptr_ack", 32'(a), 32'd0);
      xbyte(8'hC3, 1'b1, rx, a);
      xbyte(8'h5A, 1'b1, rx, a);
      i2c_stop();
      repeat (4) @(negedge clk);
      chk("t2_npulse", 32'(wq.size()), 32'(n0 + 2));
      if (wq.size() >= n0 + 2) begin
         chk("t2_w15", 32'(wq[n0]), 32'hFC3);
         chk("t2_wrap", 32'(wq[n0 + 1]), 32'h05A);
      end
      i2c_start();
      xbyte(8'hAA, 1'b1, rx, a);
      xbyte(8'h0F, 1'b1, rx, a);  chk("t2_ptr2_ack", 32'(a), 32'd0);
      i2c_start();
      xbyte(8'hAB, 1'b1, rx, a);  chk("t2_raddr_ack", 32'(a), 32'd0);
      xbyte(8'hFF, 1'b0, rx, a);  chk("t2_rd15", 32'(rx), 32'hC3);
      xbyte(8'hFF, 1'b1, rx, a);  chk("t2_rd0", 32'(rx), 32'h5A);
      chk("t2_nack_line", 32'(a), 32'd1);
      repeat (6) @(negedge clk);
      chk("t2_release", 32'(sda_oe), 32'd0);
      i2c_stop();
      repeat (4) @(negedge clk);
      chk("t2_busy_stop", 32'(busy), 32'd0);

      // Foreign address is ignored
      n0 = wq.size();
      o0 = oe_cnt;
      i2c_start();
      xbyte(8'h56, 1'b1, rx, a);  chk("t3_nack", 32'(a), 32'd1);
      chk("t3_busy", 32'(busy), 32'd0);
      xbyte(8'h77, 1'b1, rx, a);  chk("t3_ignored", 32'(a), 32'd1);
      i2c_stop();
      repeat (4) @(negedge clk);
      chk("t3_no_drive", 32'(oe_cnt - o0), 32'd0);
      chk("t3_no_pulse", 32'(wq.size()), 32'(n0));

      // STOP after four data bits
      n0 = wq.size();
      i2c_start();
      xbyte(8'hAA, 1'b1, rx, a);
      xbyte(8'h07, 1'b1, rx, a);  chk("t4_ptr_ack", 32'(a), 32'd0);
      send_bit(1'b1, t);
      send_bit(1'b0, t);
      send_bit(1'b1, t);
      send_bit(1'b0, t);
      i2c_stop();
      @(negedge clk);
      chk("t4_sda_oe", 32'(sda_oe), 32'd0);
      repeat (3) @(negedge clk);
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_no_pulse", 32'(wq.size()), 32'(n0));
      host_rd(4'd7, 8'h00, "t4_reg7");

      // Reset while the read-address ACK is on the bus
      i2c_start();
      for (int i = 7; i >= 0; i--) begin
         send_bit(((8'hAB >> i) & 8'h01) != 8'h00, t);
      end
      for (int i = 0; i < 100 && !sda_oe; i++) @(negedge clk);
      chk("t5_ack_driven", 32'(sda_oe), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("t5_release", 32'(sda_oe), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 16; i++) begin
         host_rd(4'(i), 8'h00, "t5_reg_reset");
      end
      i2c_stop();
      repeat (4) @(negedge clk);

      // General call address
      n0 = wq.size();
      i2c_start();
      xbyte(8'h00, 1'b1, rx, a);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
      chk("t6_gc_ack", 32'(a), 32'd0);
      xbyte(8'h5A, 1'b1, rx, a);
      i2c_stop();
      repeat (4) @(negedge clk);
      chk("t6_gc_pulse", 32'(wq.size()), 32'(n0 + 1));
      host_rd(4'd0, 8'h5A, "t6_gc_reg0");
`else
      chk("t6_gc_nack", 32'(a), 32'd1);
      xbyte(8'h5A, 1'b1, rx, a);
      i2c_stop();
      repeat (4) @(negedge clk);
      chk("t6_gc_no_pulse", 32'(wq.size()), 32'(n0));
      host_rd(4'd0, 8'h00, "t6_gc_reg0");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
